// File: rtl/laser_spot_centroid_if.sv
// Pixel stream into the centroid block and per-frame spot result out of it.
interface laser_spot_centroid_if;
  logic [15:0] pixel_data;
  logic        pixel_done;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        frame_done;
  logic [7:0]  threshold;
  logic [9:0]  spot_x;
  logic [9:0]  spot_y;
  logic        spot_found;
  logic        spot_valid;
  logic        frame_dropped;

  modport master (
    output pixel_data, pixel_done, hcount, vcount, frame_done, threshold,
    input  spot_x, spot_y, spot_found, spot_valid, frame_dropped
  );

  modport slave (
    input  pixel_data, pixel_done, hcount, vcount, frame_done, threshold,
    output spot_x, spot_y, spot_found, spot_valid, frame_dropped
  );
endinterface

// File: rtl/laser_spot_centroid.sv
// Thresholded-pixel centroid per frame; result strobes 30 edges after frame_done (1 edge if too few hits).
// No backpressure: pixels always accumulate, a frame_done while busy is dropped and flagged.
module laser_spot_centroid #(
  parameter int MIN_PIXELS = 4
) (
  input logic                  p_clock,
  input logic                  rst_n,
  laser_spot_centroid_if.slave bus
);
  typedef enum logic [1:0] {ACCUM, DIVIDE, REPORT} state_t;

  localparam logic [18:0] MIN_CNT = 19'(MIN_PIXELS);

  state_t      state, state_nxt;
  logic [7:0]  bright;
  logic        hit;
  logic        s1_hit;
  logic [9:0]  s1_x, s1_y;
  logic [18:0] cnt, cnt_tot;
  logic [28:0] sum_x, sum_y, sum_x_tot, sum_y_tot;
  logic [18:0] divisor;
  logic [28:0] quo_x, quo_y;
  logic [19:0] rem_x, rem_y, shx, shy;
  logic        ge_x, ge_y;
  logic [4:0]  step;
  logic        skip;
  logic        short_frame;

  assign bright = {2'b0, bus.pixel_data[15:11], 1'b0}
                + {2'b0, bus.pixel_data[10:5]}
                + {2'b0, bus.pixel_data[4:0], 1'b0};
  assign hit    = bus.pixel_done && (bright >= bus.threshold);

  // Totals include the stage-1 hit landing on this edge, so the frame snapshot is complete.
  assign cnt_tot     = cnt + {18'd0, s1_hit};
  assign sum_x_tot   = sum_x + (s1_hit ? {19'd0, s1_x} : 29'd0);
  assign sum_y_tot   = sum_y + (s1_hit ? {19'd0, s1_y} : 29'd0);
  assign short_frame = cnt_tot < MIN_CNT;

  // Restoring divider step: quotient bits shift into the low end of the dividend register.
  assign shx  = {rem_x[18:0], quo_x[28]};
  assign shy  = {rem_y[18:0], quo_y[28]};
  assign ge_x = shx >= {1'b0, divisor};
  assign ge_y = shy >= {1'b0, divisor};

  always_ff @(posedge p_clock or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (bus.frame_done) state_nxt = short_frame ? REPORT : DIVIDE;
      DIVIDE:  if (step == 5'd28) state_nxt = REPORT;
      REPORT:  state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge p_clock or negedge rst_n) begin
    if (!rst_n) begin
      s1_hit            <= 1'b0;
      s1_x              <= '0;
      s1_y              <= '0;
      cnt               <= '0;
      sum_x             <= '0;
      sum_y             <= '0;
      divisor           <= '0;
      quo_x             <= '0;
      quo_y             <= '0;
      rem_x             <= '0;
      rem_y             <= '0;
      step              <= '0;
      skip              <= 1'b0;
      bus.spot_x        <= '0;
      bus.spot_y        <= '0;
      bus.spot_found    <= 1'b0;
      bus.spot_valid    <= 1'b0;
      bus.frame_dropped <= 1'b0;
    end else begin
      s1_hit <= hit;
      if (bus.pixel_done) begin
        s1_x <= bus.hcount;
        s1_y <= bus.vcount;
      end
      bus.spot_valid    <= 1'b0;
      bus.frame_dropped <= bus.frame_done && (state != ACCUM);

      // Any frame_done starts a fresh frame; when busy the old frame is simply discarded.
      if (bus.frame_done) begin
        cnt   <= '0;
        sum_x <= '0;
        sum_y <= '0;
      end else begin
        cnt   <= cnt_tot;
        sum_x <= sum_x_tot;
        sum_y <= sum_y_tot;
      end

      case (state)
        ACCUM: if (bus.frame_done) begin
          skip    <= short_frame;
          divisor <= cnt_tot;
          quo_x   <= sum_x_tot;
          quo_y   <= sum_y_tot;
          rem_x   <= '0;
          rem_y   <= '0;
          step    <= '0;
        end
        DIVIDE: begin
          quo_x <= {quo_x[27:0], ge_x};
          quo_y <= {quo_y[27:0], ge_y};
          rem_x <= ge_x ? (shx - {1'b0, divisor}) : shx;
          rem_y <= ge_y ? (shy - {1'b0, divisor}) : shy;
          step  <= step + 5'd1;
        end
        REPORT: begin
          bus.spot_valid <= 1'b1;
          bus.spot_found <= !skip;
          if (!skip) begin
            bus.spot_x <= quo_x[9:0];
            bus.spot_y <= quo_y[9:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_laser_spot_centroid.sv
// Two instances (MIN_PIXELS 4 and 1) on the same pixel stream, checked every cycle against a frame-level model.
module tb_laser_spot_centroid;
  localparam int NE = 8192;

  logic p_clock = 1'b0;
  logic rst_n   = 1'b0;
  always #5 p_clock = ~p_clock;

  laser_spot_centroid_if bus0();
  laser_spot_centroid_if bus1();

  assign bus1.pixel_data = bus0.pixel_data;
  assign bus1.pixel_done = bus0.pixel_done;
  assign bus1.hcount     = bus0.hcount;
  assign bus1.vcount     = bus0.vcount;
  assign bus1.frame_done = bus0.frame_done;
  assign bus1.threshold  = bus0.threshold;

  laser_spot_centroid #(.MIN_PIXELS(4)) dut0 (.p_clock(p_clock), .rst_n(rst_n), .bus(bus0));
  laser_spot_centroid #(.MIN_PIXELS(1)) dut1 (.p_clock(p_clock), .rst_n(rst_n), .bus(bus1));

  int vectors = 0;
  int errors  = 0;
  int edge_n  = 0;

  // Frame-level model state per instance
  int    min_px [2] = '{4, 1};
  int    acc_c  [2];
  longint acc_x [2];
  longint acc_y [2];
  int    busy_last [2];
  bit    ev_v [2][NE];
  bit    ev_d [2][NE];
  bit    ev_f [2][NE];
  int    ev_x [2][NE];
  int    ev_y [2][NE];
  int    cur_x [2];
  int    cur_y [2];
  int    cur_f [2];
  int    vcnt  [2];
  int    dcnt  [2];
  int    last_v_edge [2] = '{-1, -1};

  always @(posedge p_clock) edge_n <= edge_n + 1;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got %0d, expected %0d", name, edge_n, act, exp);
    end
  endtask

  function automatic int bright(input logic [15:0] p);
    return 2 * int'(p[15:11]) + int'(p[10:5]) + 2 * int'(p[4:0]);
  endfunction

  always begin
    int ox [2], oy [2], of [2], ov [2], od [2];
    @(posedge p_clock);
    #1;
    ox = '{int'(bus0.spot_x), int'(bus1.spot_x)};
    oy = '{int'(bus0.spot_y), int'(bus1.spot_y)};
    of = '{int'(bus0.spot_found), int'(bus1.spot_found)};
    ov = '{int'(bus0.spot_valid), int'(bus1.spot_valid)};
    od = '{int'(bus0.frame_dropped), int'(bus1.frame_dropped)};
    for (int k = 0; k < 2; k++) begin
      int ev, ed;
      if (ov[k] == 1) begin vcnt[k]++; last_v_edge[k] = edge_n; end
      if (od[k] == 1) dcnt[k]++;
      ev = 0; ed = 0;
      if (!rst_n) begin
        cur_x[k] = 0; cur_y[k] = 0; cur_f[k] = 0;
      end else if (edge_n < NE) begin
        ev = int'(ev_v[k][edge_n]);
        ed = int'(ev_d[k][edge_n]);
        if (ev_v[k][edge_n]) begin
          cur_f[k] = int'(ev_f[k][edge_n]);
          if (ev_f[k][edge_n]) begin
            cur_x[k] = ev_x[k][edge_n];
            cur_y[k] = ev_y[k][edge_n];
          end
        end
      end
      chk($sformatf("spot_valid[%0d]", k), ov[k], ev);
      chk($sformatf("frame_dropped[%0d]", k), od[k], ed);
      chk($sformatf("spot_x[%0d]", k), ox[k], cur_x[k]);
      chk($sformatf("spot_y[%0d]", k), oy[k], cur_y[k]);
      chk($sformatf("spot_found[%0d]", k), of[k], cur_f[k]);
    end
  end

  // Drive one cycle of inputs and advance the model to the edge that samples them.
  task automatic drive(input bit pd, input logic [15:0] pix, input int h, input int v,
                       input bit fd, input int thr);
    int n;
    bus0.pixel_done = pd;
    bus0.pixel_data = pix;
    bus0.hcount     = 10'(h);
    bus0.vcount     = 10'(v);
    bus0.frame_done = fd;
    bus0.threshold  = 8'(thr);
    n = edge_n + 1;
    if (n + 31 >= NE) begin
      $display("FAIL edge_budget: edge %0d exceeds model table %0d", n, NE);
      $fatal(1);
    end
    for (int k = 0; k < 2; k++) begin
      if (fd) begin
        if (n <= busy_last[k]) begin
          ev_d[k][n] = 1'b1;
        end else if (acc_c[k] < min_px[k]) begin
          ev_v[k][n+1] = 1'b1;
          ev_f[k][n+1] = 1'b0;
          busy_last[k] = n + 1;
        end else begin
          ev_v[k][n+30] = 1'b1;
          ev_f[k][n+30] = 1'b1;
          ev_x[k][n+30] = int'(acc_x[k] / acc_c[k]);
          ev_y[k][n+30] = int'(acc_y[k] / acc_c[k]);
          busy_last[k]  = n + 30;
        end
        acc_c[k] = 0; acc_x[k] = 0; acc_y[k] = 0;
      end
      if (pd && bright(pix) >= thr) begin
        acc_c[k]++;
        acc_x[k] += h;
        acc_y[k] += v;
      end
    end
    @(negedge p_clock);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 16'h0000, 0, 0, 1'b0, 100);
  endtask

  task automatic hit(input int h, input int v);
    drive(1'b1, 16'hFFFF, h, v, 1'b0, 100);
  endtask

  task automatic frame_end(output int fd_edge);
    fd_edge = edge_n + 1;
    drive(1'b0, 16'h0000, 0, 0, 1'b1, 100);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int i = edge_n + 1; i < NE; i++) begin
        ev_v[k][i] = 1'b0; ev_d[k][i] = 1'b0;
      end
      acc_c[k] = 0; acc_x[k] = 0; acc_y[k] = 0; busy_last[k] = 0;
      cur_x[k] = 0; cur_y[k] = 0; cur_f[k] = 0;
    end
    #1;
    chk("rst_immediate_x0", int'(bus0.spot_x), 0);
    chk("rst_immediate_y0", int'(bus0.spot_y), 0);
    chk("rst_immediate_found0", int'(bus0.spot_found), 0);
    chk("rst_immediate_x1", int'(bus1.spot_x), 0);
    @(negedge p_clock);
    @(negedge p_clock);
    rst_n = 1'b1;
  endtask

  initial begin
    int fd_e, vb, db;
    logic [15:0] s100, s99;
    s100 = {5'd16, 6'd62, 5'd3};
    s99  = {5'd16, 6'd61, 5'd3};
    bus0.pixel_done = 1'b0; bus0.pixel_data = '0; bus0.hcount = '0;
    bus0.vcount = '0; bus0.frame_done = 1'b0; bus0.threshold = 8'd100;
    repeat (3) @(negedge p_clock);
    rst_n = 1'b1;
    idle(2);

    // Single hit, MIN_PIXELS=1 instance divides, MIN_PIXELS=4 instance skips
    hit(100, 50);
    idle(2);
    frame_end(fd_e);
    idle(35);
    chk("single_latency", last_v_edge[1] - fd_e, 30);
    chk("single_x", int'(bus1.spot_x), 100);
    chk("single_y", int'(bus1.spot_y), 50);
    chk("single_found", int'(bus1.spot_found), 1);
    chk("single_min4_found", int'(bus0.spot_found), 0);

    // Averaging with floor
    hit(10, 20); hit(11, 20); hit(13, 21); hit(14, 22);
    frame_end(fd_e);
    idle(35);
    chk("avg_x", int'(bus0.spot_x), 12);
    chk("avg_y", int'(bus0.spot_y), 20);
    chk("avg_found", int'(bus0.spot_found), 1);

    // Below minimum: report after one edge, position held
    hit(500, 500); hit(501, 502); hit(503, 504);
    frame_end(fd_e);
    idle(35);
    chk("short_latency", last_v_edge[0] - fd_e, 1);
    chk("short_found", int'(bus0.spot_found), 0);
    chk("short_x_held", int'(bus0.spot_x), 12);
    chk("short_y_held", int'(bus0.spot_y), 20);

    // Threshold boundary: s=100 counts, s=99 does not
    repeat (4) drive(1'b1, s100, 30, 40, 1'b0, 100);
    frame_end(fd_e);
    idle(35);
    chk("thr_eq_found", int'(bus0.spot_found), 1);
    repeat (3) drive(1'b1, s100, 30, 40, 1'b0, 100);
    drive(1'b1, s99, 30, 40, 1'b0, 100);
    frame_end(fd_e);
    idle(35);
    chk("thr_below_found", int'(bus0.spot_found), 0);

    // Overrun: second frame_done 10 cycles after the first
    db = dcnt[0];
    hit(0, 0); hit(2, 2); hit(4, 4); hit(6, 6);
    frame_end(fd_e);
    idle(4);
    hit(1000, 1000);
    idle(4);
    frame_end(fd_e);
    idle(25);
    chk("overrun_dropped", dcnt[0] - db, 1);
    chk("overrun_first_x", int'(bus0.spot_x), 3);
    chk("overrun_first_y", int'(bus0.spot_y), 3);
    hit(20, 30); hit(20, 30); hit(20, 30); hit(20, 30);
    frame_end(fd_e);
    idle(35);
    chk("overrun_next_x", int'(bus0.spot_x), 20);
    chk("overrun_next_y", int'(bus0.spot_y), 30);

    // Reset in the middle of a division
    hit(100, 100); hit(102, 100); hit(104, 100); hit(106, 100);
    frame_end(fd_e);
    idle(10);
    do_reset();
    vb = vcnt[0] + vcnt[1];
    idle(40);
    chk("rst_no_valid", vcnt[0] + vcnt[1] - vb, 0);
    hit(4, 4); hit(6, 8);
    frame_end(fd_e);
    idle(35);
    chk("post_rst_x", int'(bus1.spot_x), 5);
    chk("post_rst_y", int'(bus1.spot_y), 6);

    // Randomized frames, including pixels coincident with frame_done and overruns
    for (int f = 0; f < 30; f++) begin
      int thr, npx;
      thr = $urandom_range(60, 150);
      npx = $urandom_range(0, 14);
      for (int p = 0; p < npx; p++)
        drive(1'b1, 16'($urandom), $urandom_range(0, 1023), $urandom_range(0, 1023), 1'b0, thr);
      idle($urandom_range(0, 3));
      drive(($urandom_range(0, 3) == 0), 16'($urandom), $urandom_range(0, 1023),
            $urandom_range(0, 1023), 1'b1, thr);
      idle($urandom_range(0, 40));
    end
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
